// File: rtl/pwm_deadtime_gen_if.sv
// Gate-driver bundle for the three-phase PWM generator: modulator controls in, gate drives and status out.
interface pwm_deadtime_gen_if;
    logic       enable;
    logic       fault;
    logic [7:0] duty_a;
    logic [7:0] duty_b;
    logic [7:0] duty_c;
    logic       gate_ah;
    logic       gate_al;
    logic       gate_bh;
    logic       gate_bl;
    logic       gate_ch;
    logic       gate_cl;
    logic       period_start;
    logic       fault_latched;

    modport master (
        output enable, fault, duty_a, duty_b, duty_c,
        input  gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl,
        input  period_start, fault_latched
    );

    modport slave (
        input  enable, fault, duty_a, duty_b, duty_c,
        output gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl,
        output period_start, fault_latched
    );
endinterface

// File: rtl/pwm_deadtime_gen.sv
// Three-phase edge-aligned PWM with period-synchronous duty shadowing, per-phase dead-band FSMs
// and a sticky fault shutdown.
module pwm_deadtime_gen #(
    parameter int unsigned DEAD_TIME = 4
) (
    input  logic               clk,
    input  logic               reset,
    pwm_deadtime_gen_if.slave  pwm
);
    localparam int NPH = 3;
    localparam logic [3:0] TMR_LOAD = 4'(DEAD_TIME - 1);

    typedef enum logic [1:0] {OFF, LOW_ON, DEAD, HIGH_ON} ph_state_e;

    logic [7:0]           cnt_q, cnt_d;
    logic                 fault_q, fault_d;
    logic [NPH-1:0][7:0]  duty, shadow_q, shadow_d;
    logic [NPH-1:0]       raw, gate_h, gate_l;
    logic                 running, go;

    assign duty    = {pwm.duty_c, pwm.duty_b, pwm.duty_a};
    assign running = pwm.enable & ~fault_q;
    // A fault seen this cycle must already force the gates off next cycle, ahead of the latch.
    assign go      = running & ~pwm.fault;

    always_comb begin
        fault_d = fault_q | pwm.fault;
        cnt_d   = go ? cnt_q + 8'd1 : 8'd0;
        for (int p = 0; p < NPH; p++)
            shadow_d[p] = (!running || cnt_q == 8'hFF) ? duty[p] : shadow_q[p];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q    <= '0;
            fault_q  <= 1'b0;
            shadow_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            fault_q  <= fault_d;
            shadow_q <= shadow_d;
        end
    end

    for (genvar p = 0; p < NPH; p++) begin : g_ph
        ph_state_e  st_q, st_d;
        logic [3:0] tmr_q, tmr_d;
        logic       tgt_q, tgt_d;

        assign raw[p] = cnt_q < shadow_q[p];

        always_ff @(posedge clk) begin
            if (!reset) begin
                st_q  <= OFF;
                tmr_q <= '0;
                tgt_q <= 1'b0;
            end else begin
                st_q  <= st_d;
                tmr_q <= tmr_d;
                tgt_q <= tgt_d;
            end
        end

        // DEAD restarts its timer whenever the demand flips, so short pulses never reach a gate.
        always_comb begin
            st_d  = st_q;
            tmr_d = tmr_q;
            tgt_d = tgt_q;
            if (!go) begin
                st_d = OFF;
            end else begin
                case (st_q)
                    OFF: begin
                        st_d  = DEAD;
                        tgt_d = raw[p];
                        tmr_d = TMR_LOAD;
                    end
                    LOW_ON: if (raw[p]) begin
                        st_d  = DEAD;
                        tgt_d = 1'b1;
                        tmr_d = TMR_LOAD;
                    end
                    HIGH_ON: if (!raw[p]) begin
                        st_d  = DEAD;
                        tgt_d = 1'b0;
                        tmr_d = TMR_LOAD;
                    end
                    DEAD: begin
                        if (raw[p] != tgt_q) begin
                            tgt_d = raw[p];
                            tmr_d = TMR_LOAD;
                        end else if (tmr_q == 4'd0) begin
                            st_d = tgt_q ? HIGH_ON : LOW_ON;
                        end else begin
                            tmr_d = tmr_q - 4'd1;
                        end
                    end
                    default: st_d = OFF;
                endcase
            end
        end

        assign gate_h[p] = (st_q == HIGH_ON);
        assign gate_l[p] = (st_q == LOW_ON);
    end

    assign pwm.gate_ah       = gate_h[0];
    assign pwm.gate_al       = gate_l[0];
    assign pwm.gate_bh       = gate_h[1];
    assign pwm.gate_bl       = gate_l[1];
    assign pwm.gate_ch       = gate_h[2];
    assign pwm.gate_cl       = gate_l[2];
    assign pwm.period_start  = running & (cnt_q == 8'd0);
    assign pwm.fault_latched = fault_q;
endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Bench for pwm_deadtime_gen: directed waveform checks plus a randomized run against a
// run-length reference model (a side drives only after DT+1 consecutive running cycles of the same demand).
module tb_pwm_deadtime_gen;
    localparam int DT = 4;
    localparam int NK = 840;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pwm_deadtime_gen_if bus();
    pwm_deadtime_gen #(.DEAD_TIME(DT)) dut (.clk(clk), .reset(reset), .pwm(bus));

    logic [5:0] gvec;
    assign gvec = {bus.gate_ah, bus.gate_al, bus.gate_bh, bus.gate_bl, bus.gate_ch, bus.gate_cl};

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] ref_v);
        n_chk++;
        if (act !== ref_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, ref_v, $time);
        end
    endtask

    function automatic logic [7:0] pick_duty();
        case ($urandom_range(0, 4))
            0:       return 8'd0;
            1:       return 8'd255;
            2:       return 8'($urandom_range(1, 6));
            3:       return 8'($urandom_range(249, 254));
            default: return 8'($urandom);
        endcase
    endfunction

    // Reference model, state for the current cycle
    int m_cnt;
    int m_sh[3];
    bit m_flt;
    int m_hrun[3];
    int m_lrun[3];
    bit m_ok = 1'b0;

    always @(negedge clk) begin
        logic [7:0] dv[3];
        logic [5:0] eg;
        bit run, go, raw;
        dv[0] = bus.duty_a; dv[1] = bus.duty_b; dv[2] = bus.duty_c;
        if (m_ok) begin
            for (int p = 0; p < 3; p++) begin
                eg[5-2*p] = (m_hrun[p] > DT);
                eg[4-2*p] = (m_lrun[p] > DT);
            end
            chk("gates", gvec, eg);
            chk("period_start", bus.period_start, bus.enable && !m_flt && m_cnt == 0);
            chk("fault_latched", bus.fault_latched, m_flt);
            chk("overlap", {bus.gate_ah & bus.gate_al, bus.gate_bh & bus.gate_bl, bus.gate_ch & bus.gate_cl}, 0);
        end
        if (!reset) begin
            m_cnt = 0; m_flt = 0; m_ok = 1'b1;
            for (int p = 0; p < 3; p++) begin m_sh[p] = 0; m_hrun[p] = 0; m_lrun[p] = 0; end
        end else begin
            run = bus.enable && !m_flt;
            go  = run && !bus.fault;
            for (int p = 0; p < 3; p++) begin
                raw = m_cnt < m_sh[p];
                m_hrun[p] = (go && raw)  ? ((m_hrun[p] < 1000) ? m_hrun[p] + 1 : 1000) : 0;
                m_lrun[p] = (go && !raw) ? ((m_lrun[p] < 1000) ? m_lrun[p] + 1 : 1000) : 0;
                if (!run || m_cnt == 255) m_sh[p] = dv[p];
            end
            m_cnt = go ? (m_cnt + 1) % 256 : 0;
            m_flt = m_flt || bus.fault;
        end
    end

    logic [5:0] g_s [NK];
    logic       ps_s[NK];
    logic       fl_s[NK];

    initial begin
        int sum;
        reset = 1'b0;
        bus.enable = 1'b0; bus.fault = 1'b0;
        bus.duty_a = 8'd64; bus.duty_b = 8'd0; bus.duty_c = 8'd255;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_gates", gvec, 0);
        chk("rst_ps", bus.period_start, 0);
        chk("rst_fl", bus.fault_latched, 0);
        repeat (3) @(posedge clk);
        #1 bus.enable = 1'b1;                      // cycle E, cnt == 0

        for (int k = 0; k < NK; k++) begin
            case (k)
                356: bus.duty_a = 8'd128;           // mid-period at cnt == 100
                780: bus.fault  = 1'b1;
                781: bus.fault  = 1'b0;
                805: reset      = 1'b0;
                806: reset      = 1'b1;
                808: reset      = 1'b0;             // lands in the dead band after restart
                809: reset      = 1'b1;
                default: ;
            endcase
            @(negedge clk);
            g_s[k] = gvec; ps_s[k] = bus.period_start; fl_s[k] = bus.fault_latched;
            @(posedge clk);
            #1;
        end

        chk("ah_dead_E4", g_s[4][5], 0);
        chk("ah_on_E5", g_s[5][5], 1);
        chk("ah_on_E64", g_s[64][5], 1);
        chk("ah_off_E65", g_s[65][5], 0);
        chk("al_dead_E68", g_s[68][4], 0);
        chk("al_on_E69", g_s[69][4], 1);
        chk("al_on_E256", g_s[256][4], 1);
        chk("al_off_E257", g_s[257][4], 0);
        chk("ah_dead_E260", g_s[260][5], 0);
        chk("ah_on_E261", g_s[261][5], 1);
        sum = 0; for (int k = 0; k < 256; k++) sum += int'(g_s[k][5]);
        chk("ah_width", sum, 60);
        chk("ps_E0", ps_s[0], 1);
        chk("ps_E1", ps_s[1], 0);
        chk("ps_E256", ps_s[256], 1);
        chk("ps_E512", ps_s[512], 1);
        sum = 0; for (int k = 0; k < 700; k++) sum += int'(ps_s[k]);
        chk("ps_count", sum, 3);
        sum = 0; for (int k = 5; k < 701; k++) sum += int'(g_s[k][2]);
        chk("bl_steady", sum, 696);
        sum = 0; for (int k = 0; k < 701; k++) sum += int'(g_s[k][3]) + int'(g_s[k][0]);
        chk("bh_cl_never", sum, 0);
        chk("ch_on_cnt255", g_s[255][1], 1);
        chk("ah_old_duty_E320", g_s[320][5], 1);
        chk("ah_old_duty_E321", g_s[321][5], 0);
        chk("ah_no_early_E360", g_s[360][5], 0);
        chk("ah_new_duty_E640", g_s[640][5], 1);
        chk("ah_new_duty_E641", g_s[641][5], 0);
        chk("ah_before_fault", g_s[780][5], 1);
        sum = 0; for (int k = 781; k < 806; k++) sum += int'(g_s[k] != 6'd0);
        chk("fault_gates_off", sum, 0);
        chk("fault_latch_E781", fl_s[781], 1);
        chk("fault_sticky_E804", fl_s[804], 1);
        chk("fault_clear_E806", fl_s[806], 0);
        chk("rst_dead_E809", g_s[809], 0);
        chk("rst_dead_E813", g_s[813], 0);
        chk("rst_low_E814", g_s[814], 6'b010101);

        for (int i = 0; i < 25000; i++) begin
            reset     = 1'b1;
            bus.fault = 1'b0;
            if ($urandom_range(0, 1999) == 0 || (bus.fault_latched && $urandom_range(0, 63) == 0)) reset = 1'b0;
            if ($urandom_range(0, 399) == 0) bus.enable = ~bus.enable;
            if ($urandom_range(0, 2999) == 0) bus.fault = 1'b1;
            if ($urandom_range(0, 149) == 0) bus.duty_a = pick_duty();
            if ($urandom_range(0, 149) == 0) bus.duty_b = pick_duty();
            if ($urandom_range(0, 149) == 0) bus.duty_c = pick_duty();
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        bus.fault = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
